// File: rtl/aes_host_pkg.sv
// aes_host_pkg: shared address map, klen codes, state enum and key-length helper
package aes_host_pkg;
  localparam logic [6:0] KEY_BASE = 7'h00;
  localparam logic [6:0] TXT_BASE = 7'h20;
  localparam logic [6:0] CFG_ADDR = 7'h30;
  localparam logic [6:0] RES_BASE = 7'h40;
  localparam logic [1:0] KLEN_128 = 2'd0;
  localparam logic [1:0] KLEN_192 = 2'd1;
  localparam logic [1:0] KLEN_256 = 2'd2;
  localparam logic [1:0] KLEN_BAD = 2'd3;
  typedef enum logic [2:0] {IDLE, WR_KEY, WR_CFG, WR_TEXT, PULSE_START, WAIT_OK, RD, RESP} state_e;
  function automatic logic [5:0] nkb(input logic [1:0] klen);
    return klen == KLEN_128 ? 6'd16 : klen == KLEN_192 ? 6'd24 : klen == KLEN_256 ? 6'd32 : 6'd0;
  endfunction
endpackage

// File: rtl/aes_byte_sel.sv
// aes_byte_sel: MSB-first byte mux selecting byte idx of a 256-bit word
module aes_byte_sel (
  input  logic [255:0] data,
  input  logic [4:0]   idx,
  output logic [7:0]   sel
);
  assign sel = data[{~idx, 3'b000} +: 8];
endmodule

// File: rtl/aes_host_driver.sv
// aes_host_driver: host-side initiator running one AES block job over the chip byte bus
module aes_host_driver
  import aes_host_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int OK_MASK = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_new_key,
  input  logic [1:0]   cmd_klen,
  input  logic         cmd_op,
  input  logic [255:0] cmd_key,
  input  logic [127:0] cmd_text,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic [7:0]   DIN,
  output logic [6:0]   ADDR,
  output logic         WR,
  output logic         START,
  input  logic         OK,
  input  logic [7:0]   DOUT
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int MW = OK_MASK > 0 ? $clog2(OK_MASK + 1) : 1;
  state_e state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [MW-1:0] msk_q, msk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic key_loaded_q, key_loaded_d;
  logic [1:0] klen_q, klen_d;
  logic op_q, op_d;
  logic [255:0] key_q, key_d;
  logic [127:0] text_q, text_d;
  logic [127:0] res_q, res_d;
  logic err_q, err_d;
  logic [7:0] sel;
  logic [3:0] rd_k;
  aes_byte_sel u_sel (
    .data(state_q == WR_TEXT ? {text_q, 128'h0} : key_q),
    .idx (idx_q[4:0]),
    .sel (sel)
  );
  assign rd_k = idx_q[3:0] - 4'(RD_LAT);
  assign rsp_data = res_q;
  assign rsp_err = err_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    msk_d = msk_q;
    tmo_d = tmo_q;
    key_loaded_d = key_loaded_q;
    klen_d = klen_q;
    op_d = op_q;
    key_d = key_q;
    text_d = text_q;
    res_d = res_q;
    err_d = err_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    WR = 1'b0;
    START = 1'b0;
    ADDR = '0;
    DIN = '0;
    case (state_q)
      IDLE: begin
        cmd_ready = !RST;
        if (cmd_valid && !RST) begin
          klen_d = cmd_klen;
          op_d = cmd_op;
          key_d = cmd_key;
          text_d = cmd_text;
          res_d = '0;
          err_d = cmd_klen == KLEN_BAD;
          idx_d = '0;
          state_d = cmd_klen == KLEN_BAD ? RESP : (cmd_new_key || !key_loaded_q) ? WR_KEY : WR_CFG;
        end
      end
      WR_KEY: begin
        WR = 1'b1;
        ADDR = KEY_BASE + 7'(idx_q);
        DIN = sel;
        idx_d = idx_q + 6'd1;
        if (idx_q == nkb(klen_q) - 6'd1) begin
          idx_d = '0;
          key_loaded_d = 1'b1;
          state_d = WR_CFG;
        end
      end
      WR_CFG: begin
        WR = 1'b1;
        ADDR = CFG_ADDR;
        DIN = {op_q, 5'b0, klen_q};
        state_d = WR_TEXT;
      end
      WR_TEXT: begin
        WR = 1'b1;
        ADDR = TXT_BASE + 7'(idx_q);
        DIN = sel;
        idx_d = idx_q + 6'd1;
        if (idx_q == 6'd15) begin
          idx_d = '0;
          state_d = PULSE_START;
        end
      end
      PULSE_START: begin
        START = 1'b1;
        msk_d = '0;
        tmo_d = '0;
        state_d = WAIT_OK;
      end
      WAIT_OK: begin
        if (msk_q != MW'(OK_MASK)) msk_d = msk_q + 1'b1;
        else if (OK) begin
          idx_d = '0;
          state_d = RD;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d = 1'b1;
          key_loaded_d = 1'b0;
          state_d = RESP;
        end else tmo_d = tmo_q + 1'b1;
      end
      RD: begin
        ADDR = RES_BASE + 7'(idx_q[3:0]);
        idx_d = idx_q + 6'd1;
        if (idx_q >= 6'(RD_LAT)) res_d[{~rd_k, 3'b000} +: 8] = DOUT;
        if (idx_q == 6'(15 + RD_LAT)) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q <= '0;
      msk_q <= '0;
      tmo_q <= '0;
      key_loaded_q <= 1'b0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      msk_q <= msk_d;
      tmo_q <= tmo_d;
      key_loaded_q <= key_loaded_d;
      res_q <= res_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge CLK) begin
    klen_q <= klen_d;
    op_q <= op_d;
    key_q <= key_d;
    text_q <= text_d;
  end
endmodule
